hack_mmio_ctrl: RTL and testbench



---
 rtl/hack_mmio_pkg.sv | 15 +
 rtl/hack_mmio_debounce.sv | 56 +++++
 rtl/hack_mmio_ctrl.sv | 151 +++++++++++++++
 tb/tb_hack_mmio_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_mmio_pkg.sv
// hack_mmio_pkg: shared types and I/O window offsets for hack_mmio_ctrl.
// Contents: word_t (16-bit data word), io_ofs_t (3-bit window offset), OFS_* offsets.
package hack_mmio_pkg;

   typedef logic [15:0] word_t;
   typedef logic [2:0]  io_ofs_t;

   localparam io_ofs_t OFS_SW    = 3'd0;
   localparam io_ofs_t OFS_BTN   = 3'd1;
   localparam io_ofs_t OFS_PRESS = 3'd2;
   localparam io_ofs_t OFS_LED   = 3'd3;
   localparam io_ofs_t OFS_SEG   = 3'd4;
   localparam io_ofs_t OFS_TIMER = 3'd5;

endpackage

// File: rtl/hack_mmio_debounce.sv
// hack_mmio_debounce: 2-flop synchroniser plus per-bit hold counter.
// Ports: clk, reset_n (async, active-low), din[WIDTH] raw pins, stable[WIDTH] accepted levels.
module hack_mmio_debounce
   import hack_mmio_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int CYCLES = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] stable
);

   localparam int CW = $clog2(CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic [WIDTH-1:0]         sync1_q, sync1_d;
   logic [WIDTH-1:0]         sync2_q, sync2_d;
   logic [WIDTH-1:0]         stable_q, stable_d;
   logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d  = din;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (sync2_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == LAST) begin
            stable_d[i] = sync2_q[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/hack_mmio_ctrl.sv
// hack_mmio_ctrl: Hack data-space bridge to RAM and an 8-word I/O register window.
// Ports: clk, reset_n; CPU addressM/outM/writeM/inM; RAM ram_addr/ram_data_in/ram_we/ram_data_out;
// board sw_in, btn_in, led_out, seg_out. Define HACK_MMIO_TIMER_EN to add the tick timer at offset 5.
module hack_mmio_ctrl
   import hack_mmio_pkg::*;
#(
   parameter int          NUM_SW          = 16,
   parameter int          NUM_BTN         = 5,
   parameter int          NUM_LED         = 16,
   parameter logic [14:0] IO_BASE         = 15'h4000,
   parameter int          DEBOUNCE_CYCLES = 1000000,
   parameter int          TICK_DIV        = 100000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [14:0]        addressM,
   input  logic [15:0]        outM,
   input  logic               writeM,
   output logic [15:0]        inM,
   output logic [13:0]        ram_addr,
   output logic [15:0]        ram_data_in,
   output logic               ram_we,
   input  logic [15:0]        ram_data_out,
   input  logic [NUM_SW-1:0]  sw_in,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [NUM_LED-1:0] led_out,
   output logic [15:0]        seg_out
);

   logic [NUM_SW-1:0]  sw_stable;
   logic [NUM_BTN-1:0] btn_stable;
   logic [NUM_BTN-1:0] btn_prev_q, btn_prev_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] press_evt, clr;
   logic [NUM_LED-1:0] led_q, led_d;
   word_t              seg_q, seg_d;
   word_t              rd_io;
   io_ofs_t            ofs;
   logic               ram_sel, io_sel, io_we;

   hack_mmio_debounce #(.WIDTH(NUM_SW), .CYCLES(DEBOUNCE_CYCLES)) u_sw (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (sw_in),
      .stable (sw_stable)
   );

   hack_mmio_debounce #(.WIDTH(NUM_BTN), .CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (btn_in),
      .stable (btn_stable)
   );

   // IO_BASE is 8-aligned and >= 0x4000, so the window never overlaps RAM.
   assign ram_sel = ~addressM[14];
   assign io_sel  = (addressM[14:3] == IO_BASE[14:3]);
   assign ofs     = addressM[2:0];
   assign io_we   = writeM & io_sel;

   assign ram_addr    = addressM[13:0];
   assign ram_data_in = outM;
   assign ram_we      = writeM & ram_sel & reset_n;

   always_comb begin
      btn_prev_d = btn_stable;
      press_evt  = btn_stable & ~btn_prev_q;
      clr        = '0;
      led_d      = led_q;
      seg_d      = seg_q;
      if (io_we && ofs == OFS_PRESS) clr = outM[NUM_BTN-1:0];
      if (io_we && ofs == OFS_LED) led_d = outM[NUM_LED-1:0];
      if (io_we && ofs == OFS_SEG) seg_d = outM;
      // Set term applied after the clear so a same-edge press survives.
      press_d = (press_q & ~clr) | press_evt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_prev_q <= '0;
         press_q    <= '0;
         led_q      <= '0;
         seg_q      <= '0;
      end else begin
         btn_prev_q <= btn_prev_d;
         press_q    <= press_d;
         led_q      <= led_d;
         seg_q      <= seg_d;
      end
   end

`ifdef HACK_MMIO_TIMER_EN
   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   word_t         timer_q, timer_d;

   always_comb begin
      presc_d = presc_q + PW'(1);
      timer_d = timer_q;
      if (io_we && ofs == OFS_TIMER) begin
         timer_d = outM;
         presc_d = '0;
      end else if (presc_q == PLAST) begin
         presc_d = '0;
         timer_d = timer_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q <= '0;
         timer_q <= '0;
      end else begin
         presc_q <= presc_d;
         timer_q <= timer_d;
      end
   end
`else
   localparam int TICK_DIV_UNUSED = TICK_DIV;
`endif

   always_comb begin
      rd_io = '0;
      case (ofs)
         OFS_SW:    rd_io[NUM_SW-1:0]  = sw_stable;
         OFS_BTN:   rd_io[NUM_BTN-1:0] = btn_stable;
         OFS_PRESS: rd_io[NUM_BTN-1:0] = press_q;
         OFS_LED:   rd_io[NUM_LED-1:0] = led_q;
         OFS_SEG:   rd_io              = seg_q;
`ifdef HACK_MMIO_TIMER_EN
         OFS_TIMER: rd_io              = timer_q;
`endif
         default:   rd_io              = '0;
      endcase
   end

   always_comb begin
      inM = '0;
      unique case (1'b1)
         ram_sel: inM = ram_data_out;
         io_sel:  inM = rd_io;
         default: inM = '0;
      endcase
   end

   assign led_out = led_q;
   assign seg_out = seg_q;

endmodule

// File: tb/tb_hack_mmio_ctrl.sv
// tb_hack_mmio_ctrl: directed bench with a window-based reference model of hack_mmio_ctrl.
// Build with or without HACK_MMIO_TIMER_EN; timer expectations follow the macro.
module tb_hack_mmio_ctrl;

   localparam int          DEB     = 4;
   localparam int          TDIV    = 10;
   localparam logic [14:0] IO_BASE = 15'h4000;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [14:0] addressM;
   logic [15:0] outM;
   logic        writeM;
   logic [15:0] inM;
   logic [13:0] ram_addr;
   logic [15:0] ram_data_in;
   logic        ram_we;
   logic [15:0] ram_data_out;
   logic [15:0] sw_in;
   logic [4:0]  btn_in;
   logic [15:0] led_out;
   logic [15:0] seg_out;

   int n_checks = 0;
   int n_fail   = 0;

   hack_mmio_ctrl #(
      .NUM_SW(16), .NUM_BTN(5), .NUM_LED(16), .IO_BASE(IO_BASE),
      .DEBOUNCE_CYCLES(DEB), .TICK_DIV(TDIV)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .addressM(addressM), .outM(outM), .writeM(writeM), .inM(inM),
      .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_we(ram_we),
      .ram_data_out(ram_data_out),
      .sw_in(sw_in), .btn_in(btn_in),
      .led_out(led_out), .seg_out(seg_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got,
                      input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model. A debounced bit takes a new value once the last DEB
   // samples seen after the 2-cycle synchroniser all disagree with it.
   logic [15:0] sw_pipe[$];
   logic [15:0] sw_win[$];
   logic [15:0] btn_pipe[$];
   logic [15:0] btn_win[$];
   logic [15:0] m_sw, m_btn, m_btn_prev, m_press, m_led, m_seg, m_tload;
   int          m_tcyc;
   logic        m_iow;
   logic [2:0]  m_ofs;
   logic [15:0] m_evt, m_clr, m_seen;

   function automatic logic [15:0] settle(input logic [15:0] win[$],
                                          input logic [15:0] st);
      logic [15:0] r;
      logic        all;
      r = st;
      if (win.size() == DEB) begin
         for (int b = 0; b < 16; b++) begin
            all = 1'b1;
            foreach (win[i]) if (win[i][b] == st[b]) all = 1'b0;
            if (all) r[b] = ~st[b];
         end
      end
      return r;
   endfunction

   task automatic mreset();
      sw_pipe = '{16'h0, 16'h0};
      btn_pipe = '{16'h0, 16'h0};
      sw_win.delete();
      btn_win.delete();
      m_sw = '0; m_btn = '0; m_btn_prev = '0; m_press = '0;
      m_led = '0; m_seg = '0; m_tload = '0; m_tcyc = 0;
   endtask

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mreset();
      end else begin
         m_iow = writeM && (addressM[14:3] == IO_BASE[14:3]);
         m_ofs = addressM[2:0];
         m_evt = m_btn & ~m_btn_prev;
         m_clr = (m_iow && m_ofs == 3'd2) ? outM : 16'h0;
         m_press = (m_press & ~m_clr) | m_evt;
         m_btn_prev = m_btn;
         if (m_iow && m_ofs == 3'd3) m_led = outM;
         if (m_iow && m_ofs == 3'd4) m_seg = outM;
         if (m_iow && m_ofs == 3'd5) begin
            m_tload = outM;
            m_tcyc = 0;
         end else begin
            m_tcyc++;
         end
         m_seen = sw_pipe.pop_front();
         sw_pipe.push_back(sw_in);
         sw_win.push_back(m_seen);
         if (sw_win.size() > DEB) void'(sw_win.pop_front());
         m_sw = settle(sw_win, m_sw);
         m_seen = btn_pipe.pop_front();
         btn_pipe.push_back({11'h0, btn_in});
         btn_win.push_back(m_seen);
         if (btn_win.size() > DEB) void'(btn_win.pop_front());
         m_btn = settle(btn_win, m_btn);
      end
   end

   function automatic logic [15:0] exp_inm();
      logic [15:0] t;
      t = 16'h0;
`ifdef HACK_MMIO_TIMER_EN
      t = 16'(int'(m_tload) + m_tcyc / TDIV);
`endif
      if (!addressM[14]) return ram_data_out;
      if (addressM[14:3] != IO_BASE[14:3]) return 16'h0;
      case (addressM[2:0])
         3'd0: return m_sw;
         3'd1: return m_btn;
         3'd2: return m_press;
         3'd3: return m_led;
         3'd4: return m_seg;
         3'd5: return t;
         default: return 16'h0;
      endcase
   endfunction

   always @(negedge clk) begin
      chk("inM", inM, exp_inm());
      chk("led_out", led_out, m_led);
      chk("seg_out", seg_out, m_seg);
      chk("ram_we", {15'h0, ram_we},
          {15'h0, writeM & ~addressM[14] & reset_n});
      chk("ram_addr", {2'b0, ram_addr}, {2'b0, addressM[13:0]});
      chk("ram_data_in", ram_data_in, outM);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [14:0] a, input logic [15:0] d);
      addressM = a;
      outM = d;
      writeM = 1'b1;
      step(1);
      writeM = 1'b0;
   endtask

`ifdef HACK_MMIO_TIMER_EN
   localparam logic [15:0] T100  = 16'd10;
   localparam logic [15:0] TFULL = 16'hFFFF;
`else
   localparam logic [15:0] T100  = 16'd0;
   localparam logic [15:0] TFULL = 16'd0;
`endif

   initial begin
      reset_n = 1'b0;
      sw_in = 16'hFFFF;
      btn_in = '0;
      addressM = 15'd16;
      outM = 16'h5555;
      writeM = 1'b1;
      ram_data_out = 16'hC0DE;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_led", led_out, 16'h0);
      chk("rst_seg", seg_out, 16'h0);
      chk("rst_we", {15'h0, ram_we}, 16'h0);
      step(1);
      writeM = 1'b0;
      addressM = IO_BASE;
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("sw_rst_early", inM, 16'h0);
      end
      @(negedge clk);
      chk("sw_rst_6", inM, 16'hFFFF);

      step(1);
      sw_in = 16'h0;
      step(10);
      sw_in = 16'hAAAA;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("deb_early", inM, 16'h0);
      end
      @(negedge clk);
      chk("deb_6", inM, 16'hAAAA);

      step(1);
      sw_in = 16'h0;
      step(10);
      sw_in = 16'h0001;
      step(3);
      sw_in = 16'h0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("glitch", inM, 16'h0);
      end

      step(1);
      addressM = IO_BASE + 15'd2;
      btn_in = 5'b00101;
      step(10);
      btn_in = 5'b0;
      step(10);
      @(negedge clk);
      chk("press_sticky", inM, 16'h0005);
      step(1);
      wr(IO_BASE + 15'd2, 16'h0004);
      @(negedge clk);
      chk("press_w1c", inM, 16'h0001);
      step(1);
      btn_in = 5'b00100;
      step(6);
      wr(IO_BASE + 15'd2, 16'h0004);
      @(negedge clk);
      chk("press_set_wins", inM, 16'h0005);
      step(1);
      btn_in = 5'b0;
      step(10);

      wr(IO_BASE + 15'd4, 16'h1234);
      @(negedge clk);
      chk("seg_wr", seg_out, 16'h1234);
      step(1);
      wr(IO_BASE + 15'd3, 16'h00FF);
      @(negedge clk);
      chk("led_wr", led_out, 16'h00FF);
      step(1);
      addressM = 15'd16;
      outM = 16'd7;
      writeM = 1'b1;
      @(negedge clk);
      chk("ram_we_wr", {15'h0, ram_we}, 16'h1);
      chk("ram_addr_wr", {2'b0, ram_addr}, 16'd16);
      chk("ram_din_wr", ram_data_in, 16'd7);
      step(1);
      writeM = 1'b0;
      addressM = 15'd5;
      @(negedge clk);
      chk("ram_rd", inM, 16'hC0DE);

      step(1);
      addressM = IO_BASE + 15'd6;
      @(negedge clk);
      chk("unmap6", inM, 16'h0);
      step(1);
      addressM = 15'h7FFF;
      @(negedge clk);
      chk("unmap7fff", inM, 16'h0);
      step(1);
      wr(IO_BASE + 15'd6, 16'hFFFF);
      wr(IO_BASE + 15'd7, 16'hFFFF);
      wr(15'h7FFF, 16'hFFFF);
      @(negedge clk);
      chk("unmap_led", led_out, 16'h00FF);
      chk("unmap_seg", seg_out, 16'h1234);

      step(1);
      addressM = IO_BASE;
      sw_in = 16'hF0F0;
      step(3);
      reset_n = 1'b0;
      step(1);
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("rst_discard", inM, 16'h0);
      end
      @(negedge clk);
      chk("rst_resync", inM, 16'hF0F0);
      step(1);
      addressM = IO_BASE + 15'd5;
      repeat (93) @(posedge clk);
      @(negedge clk);
      chk("timer100", inM, T100);
      step(1);
      wr(IO_BASE + 15'd5, 16'hFFFF);
      @(negedge clk);
      chk("timer_load", inM, TFULL);
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("timer_hold", inM, TFULL);
      @(negedge clk);
      chk("timer_wrap", inM, 16'h0);

      step(2);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
